// File: rtl/aes_run_controller.sv
// rtl/aes_run_controller.sv - AES encrypt/decrypt/self-check run sequencer
//
// Runs one encrypt -> decrypt -> round-trip compare pass over the AES core
// triplets. The run is started from IDLE. The mode is chosen from sw with
// priority 128 > 192 > 256, and the plaintext is latched at start. The
// controller waits out the latency of the selected core, captures the
// ciphertext and feeds it to the decrypt cores. It then waits again,
// captures the decrypted text and compares it with the latched plaintext.
//
// Build option: define AES_CTRL_SELFCHECK_EN to include the decrypt phase
// and the compare. Without it, a run ends right after ciphertext capture.
// In that build dec_en stays 0 and pass stays 0.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   sw[2:0]           mode select (bit0=128, bit1=192, bit2=256)
//   start             run request, sampled in IDLE only
//   plaintext[127:0]  state to encrypt, latched at start accept
//   enc_out_*         encrypt core outputs (128/192/256)
//   dec_out_*         decrypt core outputs (128/192/256)
//   cipher_out        captured ciphertext, drives all decrypt core inputs
//   dec_en[2:0]       one-hot decrypt enable for the selected core, or 0
//   result            last captured value (ciphertext, then decrypted text)
//   busy              high from the cycle after start accept until DONE exit
//   done              one-cycle pulse at run end
//   pass              round-trip match, held until the next start accept
//   err               one-cycle pulse when start is seen with sw == 0
module aes_run_controller #(
    parameter int LAT_128 = 11,
    parameter int LAT_192 = 13,
    parameter int LAT_256 = 15,
    parameter int CNT_W   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   sw,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] enc_out_128,
    input  logic [127:0] enc_out_192,
    input  logic [127:0] enc_out_256,
    input  logic [127:0] dec_out_128,
    input  logic [127:0] dec_out_192,
    input  logic [127:0] dec_out_256,
    output logic [127:0] cipher_out,
    output logic [2:0]   dec_en,
    output logic [127:0] result,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC_WAIT,
        S_DEC_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    logic [1:0]         mode;      // latched: 0=128, 1=192, 2=256
    logic [CNT_W-1:0]   cnt;
    logic [127:0]       pt_q;

    logic [1:0]         sw_mode;
    logic [CNT_W-1:0]   cnt_last;
    logic [127:0]       enc_sel;
    logic [127:0]       dec_sel;

    // Lowest set sw bit wins. The value is only used when sw != 0.
    always_comb begin
        sw_mode = 2'd2;
        if (sw[0]) begin
            sw_mode = 2'd0;
        end else if (sw[1]) begin
            sw_mode = 2'd1;
        end
    end

    // Every latency compare and core mux uses the latched mode. This keeps
    // sw changes during a run from having any effect.
    always_comb begin
        cnt_last = CNT_W'(LAT_128 - 1);
        enc_sel  = enc_out_128;
        dec_sel  = dec_out_128;
        case (mode)
            2'd1: begin
                cnt_last = CNT_W'(LAT_192 - 1);
                enc_sel  = enc_out_192;
                dec_sel  = dec_out_192;
            end
            2'd2: begin
                cnt_last = CNT_W'(LAT_256 - 1);
                enc_sel  = enc_out_256;
                dec_sel  = dec_out_256;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode       <= 2'd0;
            cnt        <= '0;
            pt_q       <= '0;
            cipher_out <= '0;
            result     <= '0;
            dec_en     <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // done and err are pulses; any state that wants them re-asserts them.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (sw == 3'b000) begin
                            err <= 1'b1;
                        end else begin
                            mode  <= sw_mode;
                            pt_q  <= plaintext;
                            pass  <= 1'b0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= S_ENC_WAIT;
                        end
                    end
                end

                S_ENC_WAIT: begin
                    if (cnt == cnt_last) begin
                        cipher_out <= enc_sel;
                        result     <= enc_sel;
                        cnt        <= '0;
`ifdef AES_CTRL_SELFCHECK_EN
                        dec_en     <= 3'b001 << mode;
                        state      <= S_DEC_WAIT;
`else
                        done       <= 1'b1;
                        state      <= S_DONE;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DEC_WAIT: begin
                    if (cnt == cnt_last) begin
                        result <= dec_sel;
                        cnt    <= '0;
                        state  <= S_CHECK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_CHECK: begin
                    pass   <= (result == pt_q);
                    dec_en <= 3'b000;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_run_controller.sv
// tb/tb_aes_run_controller.sv - self-checking bench for aes_run_controller
module tb_aes_run_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   sw;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] enc_out_128, enc_out_192, enc_out_256;
    logic [127:0] dec_out_128, dec_out_192, dec_out_256;
    logic [127:0] cipher_out;
    logic [2:0]   dec_en;
    logic [127:0] result;
    logic         busy, done, pass, err;

    // Core stand-ins: "encryption" is an XOR with a per-mode key, and the
    // decrypt side undoes it. An optional per-mode corruption breaks the
    // round trip.
    logic [127:0] key [3];
    logic [127:0] bad [3];
    logic [127:0] core_pt;

    assign enc_out_128 = core_pt ^ key[0];
    assign enc_out_192 = core_pt ^ key[1];
    assign enc_out_256 = core_pt ^ key[2];
    assign dec_out_128 = cipher_out ^ key[0] ^ bad[0];
    assign dec_out_192 = cipher_out ^ key[1] ^ bad[1];
    assign dec_out_256 = cipher_out ^ key[2] ^ bad[2];

    aes_run_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .start       (start),
        .plaintext   (plaintext),
        .enc_out_128 (enc_out_128),
        .enc_out_192 (enc_out_192),
        .enc_out_256 (enc_out_256),
        .dec_out_128 (dec_out_128),
        .dec_out_192 (dec_out_192),
        .dec_out_256 (dec_out_256),
        .cipher_out  (cipher_out),
        .dec_en      (dec_en),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err         (err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int lat_tab [3] = '{11, 13, 15};
    int n_total = 0;
    int n_pass  = 0;
    logic [127:0] prev_cipher = '0;

`ifdef AES_CTRL_SELFCHECK_EN
    localparam bit SELFCHECK = 1'b1;
`else
    localparam bit SELFCHECK = 1'b0;
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int mode_of(input logic [2:0] s);
        for (int i = 0; i < 3; i++) begin
            if (s[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete run, starting from a negedge with the DUT in IDLE.
    // Expectations come from the mode's latency and the XOR core model.
    task automatic do_run(input logic [2:0] s, input logic [127:0] pt,
                          input logic [127:0] corrupt, input bit mid_change);
        int m, lat, dk;
        logic [127:0] ct, res, exp_den;
        logic exp_pass;
        m       = mode_of(s);
        lat     = lat_tab[m];
        bad[0]  = '0;
        bad[1]  = '0;
        bad[2]  = '0;
        bad[m]  = corrupt;
        core_pt = pt;
        ct      = pt ^ key[m];
        if (SELFCHECK) begin
            dk       = 2 * lat + 1;
            res      = ct ^ key[m] ^ corrupt;
            exp_pass = (res == pt);
            exp_den  = 128'(1) << m;
        end else begin
            dk       = lat;
            res      = ct;
            exp_pass = 1'b0;
            exp_den  = '0;
        end
        sw        = s;
        plaintext = pt;
        start     = 1'b1;
        for (int k = 0; k <= dk + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                chk("busy_after_accept", 128'(busy), 128'(1));
                chk("pass_cleared", 128'(pass), 128'(0));
                chk("no_err_on_accept", 128'(err), 128'(0));
            end
            if (mid_change && k == 5) begin
                sw        = 3'b100;
                plaintext = ~pt;
                start     = 1'b1;
            end
            if (mid_change && k == 6) start = 1'b0;
            if (k == lat - 1) chk("cipher_before_lat", cipher_out, prev_cipher);
            if (k == lat) begin
                chk("cipher_at_lat", cipher_out, ct);
                chk("result_cipher", result, ct);
                chk("dec_en_at_lat", 128'(dec_en), exp_den);
            end
            if (SELFCHECK && k == 2 * lat) chk("result_decrypt", result, res);
            chk("done_timing", 128'(done), 128'(k == dk));
            if (k == dk) begin
                chk("pass_at_done", 128'(pass), 128'(exp_pass));
                chk("result_at_done", result, res);
                chk("busy_at_done", 128'(busy), 128'(1));
            end
            if (k == dk + 1) begin
                chk("busy_after_done", 128'(busy), 128'(0));
                chk("dec_en_after_done", 128'(dec_en), 128'(0));
                chk("pass_held", 128'(pass), 128'(exp_pass));
            end
        end
        prev_cipher = ct;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cipher"}, cipher_out, '0);
        chk({tag, "_result"}, result, '0);
        chk({tag, "_dec_en"}, 128'(dec_en), '0);
        chk({tag, "_busy"}, 128'(busy), '0);
        chk({tag, "_done"}, 128'(done), '0);
        chk({tag, "_pass"}, 128'(pass), '0);
        chk({tag, "_err"}, 128'(err), '0);
    endtask

    initial begin
        logic [2:0]   rs;
        logic [127:0] rpt, rbad, hct;
        int           abort_k, seen;
        logic         hexp;

        rst_n     = 1'b0;
        sw        = 3'b000;
        start     = 1'b0;
        plaintext = '0;
        core_pt   = '0;
        for (int i = 0; i < 3; i++) begin
            key[i] = '0;
            bad[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        // Known-answer runs; each key is chosen so the stand-in reproduces the vector.
        key[0] = PT ^ CT_128;
        key[1] = PT ^ CT_192;
        key[2] = PT ^ CT_256;
        do_run(3'b001, PT, '0, 1'b0);
        do_run(3'b010, PT, '0, 1'b0);
        do_run(3'b100, PT, '0, 1'b0);

        // Start with no mode selected.
        sw    = 3'b000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 128'(err), 128'(1));
        chk("err_not_busy", 128'(busy), 128'(0));
        @(negedge clk);
        chk("err_one_cycle", 128'(err), 128'(0));
        chk("err_still_idle", 128'(busy), 128'(0));

        // Two mode bits: 192 wins.
        do_run(3'b110, PT, '0, 1'b0);
        // sw/plaintext changes and a start pulse mid-run are ignored.
        do_run(3'b001, PT, '0, 1'b1);
        // Broken decrypt output.
        do_run(3'b001, PT, 128'h1, 1'b0);

        // Randomised runs.
        for (int i = 0; i < 8; i++) begin
            rs = 3'($urandom_range(1, 7));
            rpt = rnd128();
            for (int j = 0; j < 3; j++) key[j] = rnd128();
            rbad = ($urandom_range(0, 1) == 1) ? rnd128() : '0;
            do_run(rs, rpt, rbad, 1'b0);
        end

        // Start held through DONE exit: a new run starts straight away.
        key[0]  = PT ^ CT_128;
        bad[0]  = '0;
        core_pt = PT;
        hct     = CT_128;
        hexp    = SELFCHECK;
        sw        = 3'b001;
        plaintext = PT;
        start     = 1'b1;
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("held_first_done", 128'(done), 128'(1));
        chk("held_first_pass", 128'(pass), 128'(hexp));
        @(negedge clk);
        chk("held_idle_gap", 128'(busy), 128'(0));
        @(negedge clk);
        start = 1'b0;
        chk("held_restart_busy", 128'(busy), 128'(1));
        chk("held_restart_pass_clr", 128'(pass), 128'(0));
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("held_second_done", 128'(done), 128'(1));
        chk("held_second_cipher", cipher_out, hct);
        @(negedge clk);
        prev_cipher = hct;

        // Reset during a run aborts it at once.
        abort_k   = SELFCHECK ? 15 : 5;
        sw        = 3'b001;
        plaintext = PT;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (abort_k) @(negedge clk);
        chk("abort_busy_before", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("abort_no_done", 128'(done), 128'(0));
        end
        chk("abort_idle", 128'(busy), 128'(0));
        prev_cipher = '0;

        // Normal operation after the abort.
        do_run(3'b001, PT, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
